// File: rtl/bcd_xs3_serial_conv.sv
// rtl/bcd_xs3_serial_conv.sv - digit-serial BCD <-> excess-3 word converter
//
// Purpose:
//   Accepts a word of DIGITS 4-bit digits with a direction bit.
//   Converts it one digit per clock, least significant digit first.
//   Presents the converted word with a sticky invalid-digit flag.
//
// Ports:
//   clk        in   1            single clock, rising edge
//   rst        in   1            synchronous, active-high reset
//   in_valid   in   1            input word offered
//   in_ready   out  1            word accepted this cycle (IDLE only)
//   mode       in   1            0: BCD->XS3, 1: XS3->BCD (sampled with din)
//   din        in   4*DIGITS     input word, digit i at [4i+3:4i]
//   out_valid  out  1            dout/err hold a completed result (DONE)
//   out_ready  in   1            consumer takes the result
//   dout       out  4*DIGITS     converted word, same digit layout as din
//   err        out  1            at least one digit of the result was invalid

module bcd_xs3_serial_conv #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   dout,
    output logic                  err
);

    // The index needs at least one bit even when there is a single digit.
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   mode_q, mode_d;
    logic [4*DIGITS-1:0]    din_q, din_d;
    logic [4*DIGITS-1:0]    dout_q, dout_d;
    logic                   err_q, err_d;

    logic [3:0]             cur_digit;
    logic [3:0]             conv_digit;
    logic                   conv_bad;

    // Single-digit conversion; invalid codes map to 4'hF and raise bad.
    // Plain 4-bit arithmetic: nothing carries into neighbouring digits.
    function automatic logic [4:0] convert_digit(input logic m, input logic [3:0] d);
        logic [3:0] res;
        logic       bad;
        res = 4'hF;
        bad = 1'b0;
        if (!m) begin
            if (d <= 4'd9) begin
                res = d + 4'd3;
            end else begin
                bad = 1'b1;
            end
        end else begin
            if ((d >= 4'd3) && (d <= 4'd12)) begin
                res = d - 4'd3;
            end else begin
                bad = 1'b1;
            end
        end
        return {bad, res};
    endfunction

    // Select the digit currently addressed by the index from the latched word.
    always_comb begin
        cur_digit = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit = din_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        {conv_bad, conv_digit} = convert_digit(mode_q, cur_digit);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        din_d     = din_q;
        dout_d    = dout_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // The word is captured here, so later din/mode changes
                    // cannot disturb the conversion in progress.
                    din_d   = din;
                    mode_d  = mode;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = CONV;
                end
            end

            CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) begin
                        dout_d[4*i +: 4] = conv_digit;
                    end
                end
                err_d = err_q | conv_bad;
                // Stop at the last digit rather than incrementing, so the
                // index never leaves 0..DIGITS-1.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // Result registers are left untouched; only the
                    // valid indication drops.
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            din_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    assign dout = dout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// tb/tb_bcd_xs3_serial_conv.sv - directed self-checking bench for bcd_xs3_serial_conv

module tb_bcd_xs3_serial_conv;

    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic                mode;
    logic [4*DIGITS-1:0] din;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] dout;
    logic                err;

    int checks = 0;
    int errors = 0;

    bcd_xs3_serial_conv #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one word in IDLE, verify the fixed DIGITS-cycle latency,
    // the result, and the handshake back to IDLE.
    task automatic run_word(input string tag, input logic m, input logic [15:0] d,
                            input logic [15:0] exp_dout, input logic exp_err);
        chk({tag, " in_ready pre"}, 32'(in_ready), 32'd1);
        mode     = m;
        din      = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        din      = ~d;
        mode     = ~m;
        chk({tag, " in_ready conv"}, 32'(in_ready), 32'd0);
        for (int c = 1; c < DIGITS; c++) begin
            chk({tag, " out_valid early"}, 32'(out_valid), 32'd0);
            tick();
        end
        chk({tag, " out_valid early"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " dout"}, 32'(dout), 32'(exp_dout));
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
        chk({tag, " dout kept"}, 32'(dout), 32'(exp_dout));
        chk({tag, " err kept"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        int hs_cnt;
        int last_hs;

        rst       = 1'b1;
        in_valid  = 1'b0;
        mode      = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset dout", 32'(dout), 32'h0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        run_word("bcd2xs3 1234", 1'b0, 16'h1234, 16'h4567, 1'b0);
        run_word("xs32bcd C3A5", 1'b1, 16'hC3A5, 16'h9072, 1'b0);
        run_word("bcd2xs3 9870", 1'b0, 16'h9870, 16'hCBA3, 1'b0);
        run_word("bcd2xs3 12A4", 1'b0, 16'h12A4, 16'h45F7, 1'b1);
        run_word("xs32bcd 3D04", 1'b1, 16'h3D04, 16'h0FF1, 1'b1);
        run_word("bcd2xs3 edge", 1'b0, 16'h0900, 16'h3C33, 1'b0);
        run_word("xs32bcd edge", 1'b1, 16'hC32D, 16'h90FF, 1'b1);

        // Stall in DONE while new words are offered and must be ignored.
        mode     = 1'b0;
        din      = 16'h1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (DIGITS) tick();
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            din      = 16'h9999;
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall in_ready", 32'(in_ready), 32'd0);
            chk("stall dout", 32'(dout), 32'h4567);
            chk("stall err", 32'(err), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall release out_valid", 32'(out_valid), 32'd0);
        chk("stall release in_ready", 32'(in_ready), 32'd1);
        repeat (DIGITS + 1) tick();
        chk("stall no hidden word out_valid", 32'(out_valid), 32'd0);
        chk("stall no hidden word dout", 32'(dout), 32'h4567);

        // Reset in the second CONV cycle, after an invalid digit 0 set err.
        mode     = 1'b0;
        din      = 16'h12AF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset dout", 32'(dout), 32'h0);
        chk("midreset err", 32'(err), 32'd0);
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        run_word("after reset", 1'b1, 16'h4444, 16'h1111, 1'b0);

        // Reset while stalled in DONE.
        mode     = 1'b0;
        din      = 16'h5555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (DIGITS) tick();
        chk("done reset pre out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("done reset out_valid", 32'(out_valid), 32'd0);
        chk("done reset dout", 32'(dout), 32'h0);

        // Back-to-back stream with out_ready tied high: period DIGITS+2.
        acc_cnt   = 0;
        hs_cnt    = 0;
        last_hs   = -1;
        mode      = 1'b0;
        din       = 16'h0123;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3 * (DIGITS + 2); c++) begin
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                chk("stream dout", 32'(dout), 32'h3456);
                chk("stream err", 32'(err), 32'd0);
                if (last_hs >= 0) chk("stream period", 32'(c - last_hs), 32'(DIGITS + 2));
                else chk("stream first latency", 32'(c), 32'(DIGITS + 1));
                last_hs = c;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream accepts", 32'(acc_cnt), 32'd3);
        chk("stream handshakes", 32'(hs_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
